// File: rtl/sprite_motion_ctrl.sv
// Sprite display-offset sequencer: bounces a SPRITE x SPRITE image around the
// H_ACTIVE x V_ACTIVE area. Offsets are updated only at the start of vsync, so
// the frame-buffer read path never sees a mid-frame change.
module sprite_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPRITE    = 128,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       home,
    output logic [9:0] x_off,
    output logic [8:0] y_off,
    output logic       x_dir,
    output logic       y_dir,
    output logic       frame_tick
);

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    // Limits and step widened by one bit so the +STEP compare cannot overflow
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE);
    localparam logic [10:0] X_STEP = 11'(STEP);
    localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - SPRITE);
    localparam logic [9:0]  Y_STEP = 10'(STEP);

    localparam int              FD_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FD_W-1:0] FD_LAST = FD_W'(FRAME_DIV - 1);

    logic            vsync_d;
    logic            tick;
    logic            update;
    logic [FD_W-1:0] fdiv;
    dir_t            x_dir_q;
    dir_t            y_dir_q;

    logic [10:0]     x_sum;
    logic [9:0]      y_sum;
    logic [9:0]      x_next;
    logic [8:0]      y_next;
    dir_t            x_dir_next;
    dir_t            y_dir_next;

    assign tick   = vsync_d & ~vsync;
    assign update = tick & en & (fdiv == FD_LAST);

    assign x_dir = x_dir_q;
    assign y_dir = y_dir_q;

    // Next X position: step toward the current edge, clamp at the limit and reverse
    always_comb begin
        x_sum      = {1'b0, x_off} + X_STEP;
        x_next     = x_off;
        x_dir_next = x_dir_q;
        if (x_dir_q == DIR_INC) begin
            if (x_sum >= X_MAX) begin
                x_next     = X_MAX[9:0];
                x_dir_next = DIR_DEC;
            end else begin
                x_next = x_sum[9:0];
            end
        end else begin
            if ({1'b0, x_off} <= X_STEP) begin
                x_next     = '0;
                x_dir_next = DIR_INC;
            end else begin
                x_next = x_off - X_STEP[9:0];
            end
        end
    end

    // Next Y position: same bounce rule against Y_MAX
    always_comb begin
        y_sum      = {1'b0, y_off} + Y_STEP;
        y_next     = y_off;
        y_dir_next = y_dir_q;
        if (y_dir_q == DIR_INC) begin
            if (y_sum >= Y_MAX) begin
                y_next     = Y_MAX[8:0];
                y_dir_next = DIR_DEC;
            end else begin
                y_next = y_sum[8:0];
            end
        end else begin
            if ({1'b0, y_off} <= Y_STEP) begin
                y_next     = '0;
                y_dir_next = DIR_INC;
            end else begin
                y_next = y_off - Y_STEP[8:0];
            end
        end
    end

    // Frame-start detection: falling edge of vsync, pulse registered one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= tick;
        end
    end

    // Frame divider and offset/direction update; home overrides any update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fdiv    <= '0;
            x_off   <= '0;
            y_off   <= '0;
            x_dir_q <= DIR_INC;
            y_dir_q <= DIR_INC;
        end else if (home) begin
            fdiv    <= '0;
            x_off   <= '0;
            y_off   <= '0;
            x_dir_q <= DIR_INC;
            y_dir_q <= DIR_INC;
        end else if (tick && en) begin
            fdiv <= (fdiv == FD_LAST) ? '0 : fdiv + 1'b1;
            if (update) begin
                if (mode[0]) begin
                    x_off   <= x_next;
                    x_dir_q <= x_dir_next;
                end
                if (mode[1]) begin
                    y_off   <= y_next;
                    y_dir_q <= y_dir_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Testbench for sprite_motion_ctrl: two instances (default parameters and
// STEP=5/FRAME_DIV=4) checked every cycle against a frame-level model, plus
// directed checks of bounce points, gating, home and async reset.
module tb_sprite_motion_ctrl;

    localparam int XMAX = 512;
    localparam int YMAX = 352;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       en    = 1'b0;
    logic       home  = 1'b0;
    logic [1:0] mode  = 2'b00;

    logic [9:0] x_off_a, x_off_b;
    logic [8:0] y_off_a, y_off_b;
    logic       x_dir_a, x_dir_b, y_dir_a, y_dir_b, frame_tick_a, frame_tick_b;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: [0] defaults, [1] STEP=5 FRAME_DIV=4
    int step_c[2] = '{1, 5};
    int fdiv_c[2] = '{1, 4};
    int mx[2], my[2], mdx[2], mdy[2], mfd[2];
    int mtick;
    int prev_v;
    int pulses_a;
    int nfr;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .en(en), .mode(mode), .home(home),
        .x_off(x_off_a), .y_off(y_off_a), .x_dir(x_dir_a), .y_dir(y_dir_a),
        .frame_tick(frame_tick_a)
    );

    sprite_motion_ctrl #(.STEP(5), .FRAME_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .en(en), .mode(mode), .home(home),
        .x_off(x_off_b), .y_off(y_off_b), .x_dir(x_dir_b), .y_dir(y_dir_b),
        .frame_tick(frame_tick_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 0; my[k] = 0; mdx[k] = 0; mdy[k] = 0; mfd[k] = 0;
        end
        mtick  = 0;
        prev_v = 1;
    endtask

    // One bounce move along an axis of length lim
    task automatic move(input int step, input int lim, input int pos_i, input int dir_i,
                        output int pos_o, output int dir_o);
        pos_o = pos_i;
        dir_o = dir_i;
        if (dir_i == 0) begin
            if (pos_i + step >= lim) begin pos_o = lim; dir_o = 1; end
            else pos_o = pos_i + step;
        end else begin
            if (pos_i <= step) begin pos_o = 0; dir_o = 0; end
            else pos_o = pos_i - step;
        end
    endtask

    // Advance the model by one clock edge given the inputs present at that edge
    task automatic model_edge();
        int tk, p, d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk = (prev_v == 1 && vsync == 1'b0) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            if (home) begin
                mx[k] = 0; my[k] = 0; mdx[k] = 0; mdy[k] = 0; mfd[k] = 0;
            end else if (tk == 1 && en) begin
                if (mfd[k] == fdiv_c[k] - 1) begin
                    mfd[k] = 0;
                    if (mode[0]) begin
                        move(step_c[k], XMAX, mx[k], mdx[k], p, d);
                        mx[k] = p; mdx[k] = d;
                    end
                    if (mode[1]) begin
                        move(step_c[k], YMAX, my[k], mdy[k], p, d);
                        my[k] = p; mdy[k] = d;
                    end
                end else begin
                    mfd[k] = mfd[k] + 1;
                end
            end
        end
        mtick  = tk;
        prev_v = (vsync == 1'b1) ? 1 : 0;
    endtask

    task automatic check_all();
        check("a_x_off", 32'(x_off_a), 32'(mx[0]));
        check("a_y_off", 32'(y_off_a), 32'(my[0]));
        check("a_x_dir", 32'(x_dir_a), 32'(mdx[0]));
        check("a_y_dir", 32'(y_dir_a), 32'(mdy[0]));
        check("a_tick",  32'(frame_tick_a), 32'(mtick));
        check("b_x_off", 32'(x_off_b), 32'(mx[1]));
        check("b_y_off", 32'(y_off_b), 32'(my[1]));
        check("b_x_dir", 32'(x_dir_b), 32'(mdx[1]));
        check("b_y_dir", 32'(y_dir_b), 32'(mdy[1]));
        check("b_tick",  32'(frame_tick_b), 32'(mtick));
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (frame_tick_a === 1'b1) pulses_a++;
        check_all();
    endtask

    task automatic frame(input int low, input int high);
        vsync = 1'b0;
        repeat (low) cyc();
        vsync = 1'b1;
        repeat (high) cyc();
        nfr++;
    endtask

    initial begin
        int p0, sx, sy, guard;
        model_reset();
        pulses_a = 0;
        nfr = 0;

        // Reset state
        @(negedge clk);
        cyc();
        check("rst_x_off", 32'(x_off_a), 32'd0);
        check("rst_tick", 32'(frame_tick_a), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Move x to 37, then assert reset asynchronously mid-cycle
        en = 1'b1; mode = 2'b01;
        repeat (37) frame(2, 2);
        check("pre_rst_x37", 32'(x_off_a), 32'd37);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_x_off", 32'(x_off_a), 32'd0);
        check("async_y_dir", 32'(y_dir_a), 32'd0);
        check("async_b_x_off", 32'(x_off_b), 32'd0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Diagonal motion from reset; first fall gives exactly one pulse
        nfr = 0;
        mode = 2'b11;
        p0 = pulses_a;
        frame(2, 3);
        check("first_fall_pulses", 32'(pulses_a - p0), 32'd1);
        repeat (7) frame(2, 3);
        check("b_div4_step5_x10", 32'(x_off_b), 32'd10);
        repeat (2) frame(2, 3);
        check("diag10_x", 32'(x_off_a), 32'd10);
        check("diag10_y", 32'(y_off_a), 32'd10);
        check("diag10_xdir", 32'(x_dir_a), 32'd0);

        // Long vsync low gives one pulse
        p0 = pulses_a;
        frame(50, 3);
        check("long_low_pulses", 32'(pulses_a - p0), 32'd1);

        // Bounce points
        while (nfr < 352) frame(1, 2);
        check("y_at_max", 32'(y_off_a), 32'd352);
        check("y_dir_rev", 32'(y_dir_a), 32'd1);
        frame(1, 2);
        check("y_after_max", 32'(y_off_a), 32'd351);
        while (nfr < 512) frame(1, 2);
        check("x_at_max", 32'(x_off_a), 32'd512);
        check("x_dir_rev", 32'(x_dir_a), 32'd1);
        frame(1, 2);
        check("x_after_max", 32'(x_off_a), 32'd511);
        while (nfr < 1024) frame(1, 2);
        check("x_at_zero", 32'(x_off_a), 32'd0);
        check("x_dir_fwd", 32'(x_dir_a), 32'd0);

        // Gating: en=0 holds offsets but frame_tick keeps pulsing
        sx = mx[0]; sy = my[0];
        en = 1'b0;
        p0 = pulses_a;
        repeat (5) frame(2, 2);
        check("en0_pulses", 32'(pulses_a - p0), 32'd5);
        check("en0_x_hold", 32'(x_off_a), 32'(sx));
        check("en0_y_hold", 32'(y_off_a), 32'(sy));
        en = 1'b1; mode = 2'b01;
        repeat (3) frame(2, 2);
        check("xonly_x", 32'(x_off_a), 32'(sx + 3));
        check("xonly_y", 32'(y_off_a), 32'(sy));

        // home on the same edge as an update
        vsync = 1'b0; home = 1'b1;
        cyc();
        home = 1'b0;
        check("home_x", 32'(x_off_a), 32'd0);
        check("home_tick", 32'(frame_tick_a), 32'd1);
        check("home_b_x", 32'(x_off_b), 32'd0);
        cyc();
        vsync = 1'b1;
        repeat (2) cyc();
        frame(2, 2);
        check("home_next_x", 32'(x_off_a), 32'd1);
        repeat (2) frame(2, 2);
        check("home_b_fdiv_hold", 32'(x_off_b), 32'd0);
        frame(2, 2);
        check("home_b_fdiv_reset", 32'(x_off_b), 32'd5);

        // STEP=5 approaching X_MAX: 510 -> 512 (reverse) -> 507
        guard = 0;
        while (!(mx[1] == 510 && mdx[1] == 0) && guard < 600) begin
            frame(1, 1);
            guard++;
        end
        check("b_reach_510", 32'(x_off_b), 32'd510);
        repeat (4) frame(1, 1);
        check("b_clamp_512", 32'(x_off_b), 32'd512);
        check("b_clamp_dir", 32'(x_dir_b), 32'd1);
        repeat (4) frame(1, 1);
        check("b_back_507", 32'(x_off_b), 32'd507);

        // Randomised frames with random enable, mode, vsync shape and home
        for (int f = 0; f < 400; f++) begin
            en   = ($urandom_range(3) != 0);
            mode = 2'($urandom_range(3));
            vsync = 1'b0;
            for (int c = 0; c < int'($urandom_range(6, 1)); c++) begin
                home = ($urandom_range(99) < 3);
                cyc();
            end
            vsync = 1'b1;
            for (int c = 0; c < int'($urandom_range(4, 1)); c++) begin
                home = ($urandom_range(99) < 3);
                cyc();
            end
        end
        home = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
